// File: rtl/mult_8x8_arb_ctrl.sv
// Round-robin arbiter sharing one 8x8 unsigned multiplier among NREQ requesters, with flush/drain FSM.
// Latency: fixed 2 cycles from accept to res_valid; one operation per cycle.
// Backpressure: one-hot req_ready toward requesters only; results cannot stall. Optional op counter: MULT_ARB_STATS_EN.
module mult_8x8_arb_ctrl #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [15:0]       res_product,
    output logic              busy
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [15:0]       op_count
`endif
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] gnt_id;
    logic           xfer;
    logic [7:0]     a_sel;
    logic [7:0]     b_sel;

    logic           s1_valid;
    logic [IDW-1:0] s1_id;
    logic [7:0]     s1_a;
    logic [7:0]     s1_b;

    // Pick the first valid requester scanning from ptr; grants only in RUN with flush low.
    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        if (state == RUN && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = IDW'((int'(ptr) + k) % NREQ);
                if (!found && req_valid[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    gnt_id      = idx;
                end
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;

    // Route the granted requester's operands to the shared datapath.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*8 +: 8];
                b_sel = req_b[i*8 +: 8];
            end
        end
    end

    // Rotate priority past the winner; hold it when nothing transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
        end
    end

    // Stage 1: capture the accepted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_id <= gnt_id;
                s1_a  <= a_sel;
                s1_b  <= b_sel;
            end
        end
    end

    // Stage 2: full-width product; id and product forced to zero when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_product <= '0;
        end else begin
            res_valid   <= s1_valid;
            res_id      <= s1_valid ? s1_id : '0;
            res_product <= s1_valid ? ({8'd0, s1_a} * {8'd0, s1_b}) : 16'd0;
        end
    end

    // Flush control: stop granting, wait for the pipeline to empty, pulse done for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (flush) state <= DRAIN;
                DRAIN:   if (!s1_valid && !res_valid) state <= DONE;
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign flush_done = (state == DONE);
    assign busy       = s1_valid | res_valid;

`ifdef MULT_ARB_STATS_EN
    // Saturating count of accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (xfer && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_8x8_arb_ctrl.sv
// Directed bench for mult_8x8_arb_ctrl: reset, single op, round-robin contention,
// operand boundaries, flush/drain, held flush, reset mid-operation, optional counter.
module tb_mult_8x8_arb_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              flush;
    logic              flush_done;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [15:0]       res_product;
    logic              busy;
`ifdef MULT_ARB_STATS_EN
    logic [15:0]       op_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_8x8_arb_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .flush       (flush),
        .flush_done  (flush_done),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_product (res_product),
        .busy        (busy)
`ifdef MULT_ARB_STATS_EN
        ,
        .op_count    (op_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Default operand set: requester k uses a=10+k, b=20+k.
    task automatic set_ops();
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*8 +: 8] = 8'(10 + k);
            req_b[k*8 +: 8] = 8'(20 + k);
        end
    endtask

    function automatic logic [31:0] prod(input int k);
        return 32'((10 + k) * (20 + k));
    endfunction

    task automatic chk_res(input string tag, input int id, input logic [31:0] p);
        chk({tag, "_vld"}, 32'(res_valid), 32'd1);
        chk({tag, "_id"}, 32'(res_id), 32'(id));
        chk({tag, "_prod"}, 32'(res_product), p);
    endtask

    initial begin
        int exp_fd [6];
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;

        // Reset state, before any clock edge.
        #3;
        chk("rst_vld", 32'(res_valid), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_prod", 32'(res_product), 32'd0);
        chk("rst_fd", 32'(flush_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef MULT_ARB_STATS_EN
        chk("rst_cnt", 32'(op_count), 32'd0);
`endif
        repeat (2) nxt();
        rst_n = 1'b1;
        nxt();

        // Single operation: 12*13 = 156 from requester 0.
        req_a[7:0] = 8'd12;
        req_b[7:0] = 8'd13;
        req_valid  = 4'b0001;
        @(negedge clk) chk("single_rdy", 32'(req_ready), 32'b0001);
        nxt();
        req_valid = '0;
        @(negedge clk);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_early", 32'(res_valid), 32'd0);
        nxt();
        @(negedge clk) chk_res("single", 0, 32'd156);
        nxt();
        @(negedge clk);
        chk("single_after_vld", 32'(res_valid), 32'd0);
        chk("single_after_prod", 32'(res_product), 32'd0);
        chk("single_after_busy", 32'(busy), 32'd0);

        // Fresh reset, then full contention for 8 cycles.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        nxt();
        set_ops();
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            if (c < 8) chk("rr_rdy", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) chk_res("rr_res", (c - 2) % 4, prod((c - 2) % 4));
            nxt();
        end

        // Boundaries: ptr=0; req2 255*255, then req1 0*200.
        req_a[23:16] = 8'd255;
        req_b[23:16] = 8'd255;
        req_valid    = 4'b0100;
        @(negedge clk) chk("bnd_rdy2", 32'(req_ready), 32'b0100);
        nxt();
        req_a[15:8] = 8'd0;
        req_b[15:8] = 8'd200;
        req_valid   = 4'b0010;
        @(negedge clk) chk("bnd_rdy1", 32'(req_ready), 32'b0010);
        nxt();
        req_valid = '0;
        set_ops();
        @(negedge clk) chk_res("bnd_max", 2, 32'hFE01);
        nxt();
        @(negedge clk) chk_res("bnd_zero", 1, 32'h0000);
        nxt();

        // Flush with two operations in flight; ptr=2 here.
        req_valid = 4'hF;
        @(negedge clk) chk("fl_rdy2", 32'(req_ready), 32'b0100);
        nxt();
        @(negedge clk) chk("fl_rdy3", 32'(req_ready), 32'b1000);
        nxt();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_c2_rdy", 32'(req_ready), 32'd0);
        chk_res("fl_res2", 2, prod(2));
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_c3_rdy", 32'(req_ready), 32'd0);
        chk("fl_c3_fd", 32'(flush_done), 32'd0);
        chk_res("fl_res3", 3, prod(3));
        nxt();
        @(negedge clk);
        chk("fl_c4_rdy", 32'(req_ready), 32'd0);
        chk("fl_c4_vld", 32'(res_valid), 32'd0);
        chk("fl_c4_busy", 32'(busy), 32'd0);
        chk("fl_c4_fd", 32'(flush_done), 32'd0);
        nxt();
        @(negedge clk);
        chk("fl_c5_fd", 32'(flush_done), 32'd1);
        chk("fl_c5_rdy", 32'(req_ready), 32'd0);
        nxt();
        @(negedge clk);
        chk("fl_c6_fd", 32'(flush_done), 32'd0);
        chk("fl_c6_rdy", 32'(req_ready), 32'b0001);
        nxt();
        req_valid = '0;
        repeat (3) nxt();

        // Flush held high with an empty pipeline: done pulses every third cycle, never a grant.
        exp_fd = '{0, 0, 1, 0, 0, 1};
        flush     = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("hold_fd", 32'(flush_done), 32'(exp_fd[c]));
            chk("hold_rdy", 32'(req_ready), 32'd0);
            nxt();
        end
        flush     = 1'b0;
        req_valid = '0;
        nxt();

        // Reset one cycle after acceptance; ptr=1 here.
        req_valid = 4'b0010;
        @(negedge clk) chk("rst_mid_rdy", 32'(req_ready), 32'b0010);
        nxt();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_vld", 32'(res_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("rst_mid_vld2", 32'(res_valid), 32'd0);
        chk("rst_mid_prod", 32'(res_product), 32'd0);
        rst_n = 1'b1;
        nxt();
        @(negedge clk) chk("rst_post_vld", 32'(res_valid), 32'd0);
        nxt();
        req_valid = 4'b1010;
        @(negedge clk) chk("rst_post_rdy", 32'(req_ready), 32'b0010);
        nxt();
        req_valid = '0;
        repeat (3) nxt();

`ifdef MULT_ARB_STATS_EN
        // Counter: exact increments, then saturation.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        nxt();
        req_valid = 4'b0001;
        repeat (5) nxt();
        chk("cnt_5", 32'(op_count), 32'd5);
        repeat (69995) nxt();
        chk("cnt_sat", 32'(op_count), 32'hFFFF);
        repeat (3) nxt();
        chk("cnt_hold", 32'(op_count), 32'hFFFF);
        req_valid = '0;
        nxt();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mult_8x8_arb_ctrl.md
MULT_8X8_ARB_CTRL -- requirements
Module: mult_8x8_arb_ctrl

Interface
REQ-001 Parameters SHALL be as follows.
  NREQ, 4, number of requesters (2..8).
  IDW, 2, width of the requester id; SHALL equal clog2(NREQ).
REQ-002 Ports SHALL be as follows.
  clk  in  1  single clock; all state updates on its rising edge.
  rst_n  in  1  asynchronous active-low reset.
  req_valid  in  NREQ  per-requester operation request.
  req_a  in  8*NREQ  operand a; requester i uses bits [8i+7:8i].
  req_b  in  8*NREQ  operand b, packed the same way as req_a.
  req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i]&req_ready[i].
  flush  in  1  drain request, sampled each cycle.
  flush_done  out  1  one-cycle pulse when the drain completes.
  res_valid  out  1  result strobe.
  res_id  out  IDW  requester id owning the result.
  res_product  out  16  unsigned product a*b.
  busy  out  1  high when any pipeline stage holds a valid operation.
  op_count  out  16  accepted-operation counter; present only with MULT_ARB_STATS_EN.

Function
REQ-003 The block SHALL own exactly one 8x8 unsigned multiplier datapath and share it among NREQ requesters.
REQ-004 Arbitration SHALL be round-robin: priority pointer ptr, highest priority at ptr, then ptr+1 and onward modulo NREQ.
REQ-005 Ready rule: req_ready SHALL have at most one bit set; bit i SHALL be set iff state=RUN, flush=0, req_valid[i]=1 and i is the highest-priority valid requester.
REQ-006 req_ready SHALL depend combinationally on req_valid, ptr, state and flush only, never on operand values.
REQ-007 Pointer update: on a transfer from requester g, ptr SHALL become (g+1) mod NREQ; ptr SHALL be unchanged when no transfer occurs.
REQ-008 Stage 1: on a transfer, operands and id g SHALL be registered into stage 1 with s1_valid=1; otherwise s1_valid SHALL be 0.
REQ-009 Stage 2: each cycle, stage 2 SHALL register the product of the stage-1 operands together with s1_id and s1_valid.
REQ-010 Latency: res_valid, res_id and res_product SHALL be driven from stage 2, so a transfer sampled at edge t yields res_valid=1 during the cycle after edge t+1 (fixed latency of 2).
REQ-011 Throughput: one operation per cycle; results SHALL have no backpressure and SHALL be returned in acceptance order.
REQ-012 Width: res_product SHALL be the full 16-bit unsigned product; 255*255 SHALL give 16'hFE01 with no truncation.
REQ-013 res_product and res_id SHALL read 0 whenever res_valid=0.
REQ-014 busy SHALL equal s1_valid|res_valid.
REQ-015 The FSM SHALL have three states, RUN, DRAIN and DONE, with the following transitions.
  RUN -> DRAIN when flush=1.
  DRAIN -> DONE when s1_valid=0 and res_valid=0.
  DONE -> RUN unconditionally after one cycle; flush_done=1 only in DONE.
REQ-016 No grant SHALL be issued in DRAIN or DONE, or in any cycle with flush=1.
REQ-017 An operation accepted before flush was seen SHALL still complete and return its result.
REQ-018 Flush held high through DONE SHALL re-enter DRAIN from RUN on the following cycle. With the pipeline already empty, it SHALL pulse flush_done again two cycles later.
REQ-019 A requester that drops req_valid without a transfer SHALL lose nothing; no state SHALL change.

Reset
REQ-020 While rst_n=0, the following SHALL hold immediately, independent of clk.
  ptr=0, state=RUN.
  s1_valid=0, res_valid=0, res_id=0, res_product=0.
  flush_done=0, busy=0, op_count=0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight operations with no result strobe. The first grant after release SHALL follow the ptr=0 ordering.

Configuration
REQ-022 With MULT_ARB_STATS_EN defined, op_count SHALL increment by 1 on each transfer, saturate at 16'hFFFF and clear only on reset.
REQ-023 Without MULT_ARB_STATS_EN, port op_count and its counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 Single op: req_valid=4'b0001, a0=8'd12, b0=8'd13 -> ready[0] in the same cycle; 2 cycles later res_valid=1, res_id=0, res_product=16'd156.
REQ-025 Full contention: all four requesters valid for 8 cycles after reset -> grants 0,1,2,3,0,1,2,3; results back to back in the same order.
REQ-026 Boundaries: a=255, b=255 -> 16'hFE01; a=0, b=200 -> 16'h0000 with res_valid=1.
REQ-027 Flush with 2 ops in flight -> no further ready, both results delivered, flush_done pulses one cycle, then grants resume with ptr preserved.
REQ-028 Reset asserted 1 cycle after acceptance -> no res_valid afterwards, outputs 0, next grant goes to the lowest-index valid requester.
REQ-029 With MULT_ARB_STATS_EN, 70000 accepted operations -> op_count=16'hFFFF and holds.
